// File: rtl/dpram_pkg.sv
// Shared constants and write-mode decoding for the dpram_1kx18_rw block RAM.
package dpram_pkg;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 16;
  localparam int PAR_W  = 2;
  localparam int DEPTH  = 1024;

  // Output behaviour of a port on a cycle where it writes.
  typedef enum logic [1:0] {
    WM_WRITE_FIRST = 2'd0,
    WM_READ_FIRST  = 2'd1,
    WM_NO_CHANGE   = 2'd2,
    WM_INVALID     = 2'd3
  } write_mode_e;

  // Map the vendor-style mode string onto the internal encoding.
  function automatic write_mode_e wm_encode(input string mode);
    if (mode == "WRITE_FIRST") return WM_WRITE_FIRST;
    if (mode == "READ_FIRST")  return WM_READ_FIRST;
    if (mode == "NO_CHANGE")   return WM_NO_CHANGE;
    return WM_INVALID;
  endfunction

endpackage

// File: rtl/dpram_1kx18_rw_if.sv
// Bus bundle for both ports of dpram_1kx18_rw, signal names as on the S18_S18 primitive.
interface dpram_1kx18_rw_if;
  import dpram_pkg::*;

  logic [ADDR_W-1:0] ADDRA;
  logic [DATA_W-1:0] DIA;
  logic [PAR_W-1:0]  DIPA;
  logic              ENA;
  logic              WEA;
  logic              SSRA;
  logic [DATA_W-1:0] DOA;
  logic [PAR_W-1:0]  DOPA;

  logic [ADDR_W-1:0] ADDRB;
  logic [DATA_W-1:0] DIB;
  logic [PAR_W-1:0]  DIPB;
  logic              ENB;
  logic              WEB;
  logic              SSRB;
  logic [DATA_W-1:0] DOB;
  logic [PAR_W-1:0]  DOPB;

  modport master (
    output ADDRA, DIA, DIPA, ENA, WEA, SSRA,
    output ADDRB, DIB, DIPB, ENB, WEB, SSRB,
    input  DOA, DOPA, DOB, DOPB
  );

  modport slave (
    input  ADDRA, DIA, DIPA, ENA, WEA, SSRA,
    input  ADDRB, DIB, DIPB, ENB, WEB, SSRB,
    output DOA, DOPA, DOB, DOPB
  );

endinterface

// File: rtl/dpram_port_out.sv
// Registered read-data output of one RAM port: rst > EN > SSR > write mode > read.
module dpram_port_out
  import dpram_pkg::*;
#(
  parameter int          W     = DATA_W,
  parameter logic [W-1:0] INIT  = '0,
  parameter logic [W-1:0] SRVAL = '0,
  parameter write_mode_e MODE  = WM_WRITE_FIRST
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         we,
  input  logic         ssr,
  input  logic [W-1:0] wdata,   // word being written this cycle
  input  logic [W-1:0] rdata,   // array contents before this edge's writes
  output logic [W-1:0] dout
);

  // Output register update; rst wins even when the port is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= INIT;
    end else if (en) begin
      if (ssr) begin
        dout <= SRVAL;
      end else if (we) begin
        case (MODE)
          WM_WRITE_FIRST: dout <= wdata;
          WM_READ_FIRST:  dout <= rdata;
          default:        dout <= dout;
        endcase
      end else begin
        dout <= rdata;
      end
    end
  end

endmodule

// File: rtl/dpram_1kx18_rw.sv
// True dual-port 1024 x 16(+2 parity) synchronous RAM, drop-in for the S18_S18 primitive.
// Optional build macro DPRAM_PARITY_EN: when defined parity bits are stored and read;
// when undefined the array is 16 bits wide, DIP inputs are ignored and DOP reads 2'b00.
module dpram_1kx18_rw
  import dpram_pkg::*;
#(
  parameter string       WRITE_MODE_A = "WRITE_FIRST",
  parameter string       WRITE_MODE_B = "WRITE_FIRST",
  parameter logic [17:0] INIT_A       = 18'h0,
  parameter logic [17:0] INIT_B       = 18'h0,
  parameter logic [17:0] SRVAL_A      = 18'h0,
  parameter logic [17:0] SRVAL_B      = 18'h0
) (
  input  logic                 clk,
  input  logic                 rst,
  dpram_1kx18_rw_if.slave      bus
);

`ifdef DPRAM_PARITY_EN
  localparam int WORD_W = DATA_W + PAR_W;
`else
  localparam int WORD_W = DATA_W;
`endif

  localparam write_mode_e MODE_A = wm_encode(WRITE_MODE_A);
  localparam write_mode_e MODE_B = wm_encode(WRITE_MODE_B);

  if (MODE_A == WM_INVALID) begin : g_bad_mode_a
    $error("dpram_1kx18_rw: WRITE_MODE_A must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end
  if (MODE_B == WM_INVALID) begin : g_bad_mode_b
    $error("dpram_1kx18_rw: WRITE_MODE_B must be WRITE_FIRST, READ_FIRST or NO_CHANGE");
  end

  logic [WORD_W-1:0] mem [DEPTH];
  logic [WORD_W-1:0] wdata_a, wdata_b;
  logic [WORD_W-1:0] rdata_a, rdata_b;
  logic [WORD_W-1:0] dout_a, dout_b;

`ifdef DPRAM_PARITY_EN
  assign wdata_a  = {bus.DIPA, bus.DIA};
  assign wdata_b  = {bus.DIPB, bus.DIB};
  assign bus.DOA  = dout_a[DATA_W-1:0];
  assign bus.DOPA = dout_a[WORD_W-1:DATA_W];
  assign bus.DOB  = dout_b[DATA_W-1:0];
  assign bus.DOPB = dout_b[WORD_W-1:DATA_W];
`else
  logic unused_par;
  assign unused_par = ^{bus.DIPA, bus.DIPB};
  assign wdata_a  = bus.DIA;
  assign wdata_b  = bus.DIB;
  assign bus.DOA  = dout_a;
  assign bus.DOPA = '0;
  assign bus.DOB  = dout_b;
  assign bus.DOPB = '0;
`endif

  // Both ports see the pre-edge contents, so a read colliding with a write returns old data.
  assign rdata_a = mem[bus.ADDRA];
  assign rdata_b = mem[bus.ADDRB];

  // Array writes; rst deliberately does not gate them.
  // NOTE: the array has no reset -- clearing 1024 words needs a sweep, not a reset branch,
  // and a reset term would stop the array mapping onto block RAM.
  always_ff @(posedge clk) begin
    if (bus.ENA && bus.WEA) mem[bus.ADDRA] <= wdata_a;
    // NOTE: non-blocking writes take effect in statement order, so on a same-address
    // double write the later port B assignment is the one stored.
    if (bus.ENB && bus.WEB) mem[bus.ADDRB] <= wdata_b;
  end

  dpram_port_out #(
    .W     (WORD_W),
    .INIT  (INIT_A[WORD_W-1:0]),
    .SRVAL (SRVAL_A[WORD_W-1:0]),
    .MODE  (MODE_A)
  ) u_out_a (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.ENA),
    .we    (bus.WEA),
    .ssr   (bus.SSRA),
    .wdata (wdata_a),
    .rdata (rdata_a),
    .dout  (dout_a)
  );

  dpram_port_out #(
    .W     (WORD_W),
    .INIT  (INIT_B[WORD_W-1:0]),
    .SRVAL (SRVAL_B[WORD_W-1:0]),
    .MODE  (MODE_B)
  ) u_out_b (
    .clk   (clk),
    .rst   (rst),
    .en    (bus.ENB),
    .we    (bus.WEB),
    .ssr   (bus.SSRB),
    .wdata (wdata_b),
    .rdata (rdata_b),
    .dout  (dout_b)
  );

endmodule

// File: tb/tb_dpram_1kx18_rw.sv
// Bench for dpram_1kx18_rw: three instances share stimulus and differ only in port B
// write mode (WRITE_FIRST / READ_FIRST / NO_CHANGE); port A is READ_FIRST as in the
// scanline use. An array-level model predicts every output each cycle.
module tb_dpram_1kx18_rw;

`ifdef DPRAM_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif

  localparam int MODE_WF = 0;
  localparam int MODE_RF = 1;
  localparam int MODE_NC = 2;
  localparam int NDUT    = 3;

  localparam logic [17:0] INIT_A_V  = 18'h3_1234;
  localparam logic [17:0] INIT_B_V  = 18'h0_0000;
  localparam logic [17:0] SRVAL_A_V = 18'h0_0000;
  localparam logic [17:0] SRVAL_B_V = 18'h0_ABCD;

  logic        clk = 1'b0;
  logic        rst;
  logic [9:0]  addra, addrb;
  logic [15:0] dia, dib;
  logic [1:0]  dipa, dipb;
  logic        ena, wea, ssra, enb, web, ssrb;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dpram_1kx18_rw_if if0 ();
  dpram_1kx18_rw_if if1 ();
  dpram_1kx18_rw_if if2 ();

  assign {if0.ADDRA, if0.DIA, if0.DIPA, if0.ENA, if0.WEA, if0.SSRA} = {addra, dia, dipa, ena, wea, ssra};
  assign {if0.ADDRB, if0.DIB, if0.DIPB, if0.ENB, if0.WEB, if0.SSRB} = {addrb, dib, dipb, enb, web, ssrb};
  assign {if1.ADDRA, if1.DIA, if1.DIPA, if1.ENA, if1.WEA, if1.SSRA} = {addra, dia, dipa, ena, wea, ssra};
  assign {if1.ADDRB, if1.DIB, if1.DIPB, if1.ENB, if1.WEB, if1.SSRB} = {addrb, dib, dipb, enb, web, ssrb};
  assign {if2.ADDRA, if2.DIA, if2.DIPA, if2.ENA, if2.WEA, if2.SSRA} = {addra, dia, dipa, ena, wea, ssra};
  assign {if2.ADDRB, if2.DIB, if2.DIPB, if2.ENB, if2.WEB, if2.SSRB} = {addrb, dib, dipb, enb, web, ssrb};

  dpram_1kx18_rw #(
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("WRITE_FIRST"),
    .INIT_A(INIT_A_V), .INIT_B(INIT_B_V), .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)
  ) u_dut0 (.clk(clk), .rst(rst), .bus(if0));

  dpram_1kx18_rw #(
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("READ_FIRST"),
    .INIT_A(INIT_A_V), .INIT_B(INIT_B_V), .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)
  ) u_dut1 (.clk(clk), .rst(rst), .bus(if1));

  dpram_1kx18_rw #(
    .WRITE_MODE_A("READ_FIRST"), .WRITE_MODE_B("NO_CHANGE"),
    .INIT_A(INIT_A_V), .INIT_B(INIT_B_V), .SRVAL_A(SRVAL_A_V), .SRVAL_B(SRVAL_B_V)
  ) u_dut2 (.clk(clk), .rst(rst), .bus(if2));

  logic [17:0] act_a [NDUT];
  logic [17:0] act_b [NDUT];
  assign act_a[0] = {if0.DOPA, if0.DOA};
  assign act_b[0] = {if0.DOPB, if0.DOB};
  assign act_a[1] = {if1.DOPA, if1.DOA};
  assign act_b[1] = {if1.DOPB, if1.DOB};
  assign act_a[2] = {if2.DOPA, if2.DOA};
  assign act_b[2] = {if2.DOPB, if2.DOB};

  // ---------------- checking helpers ----------------
  task automatic check(input string name, input logic [17:0] act, input logic [17:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Word as the build stores it: parity is dropped when the feature is off.
  function automatic logic [17:0] fit(input logic [17:0] w);
    return PAR ? w : {2'b00, w[15:0]};
  endfunction

  function automatic int b_mode(input int k);
    return (k == 0) ? MODE_WF : (k == 1) ? MODE_RF : MODE_NC;
  endfunction

  // Output a port must show after an edge, from its inputs and the pre-edge word.
  function automatic logic [17:0] next_out(
    input logic [17:0] cur, input logic r, input logic e, input logic w, input logic s,
    input logic [17:0] wd, input logic [17:0] old, input logic [17:0] init,
    input logic [17:0] srval, input int mode);
    if (r)  return fit(init);
    if (!e) return cur;
    if (s)  return fit(srval);
    if (w) begin
      if (mode == MODE_WF) return wd;
      if (mode == MODE_RF) return old;
      return cur;
    end
    return old;
  endfunction

  // ---------------- reference model ----------------
  logic [17:0] mdl_mem [1024];
  logic [17:0] exp_a [NDUT];
  logic [17:0] exp_b [NDUT];
  bit          chk_en = 1'b0;

  initial for (int i = 0; i < 1024; i++) mdl_mem[i] = 18'h0;

  always @(posedge clk) begin
    for (int k = 0; k < NDUT; k++) begin
      exp_a[k] <= next_out(exp_a[k], rst, ena, wea, ssra, fit({dipa, dia}),
                           mdl_mem[addra], INIT_A_V, SRVAL_A_V, MODE_RF);
      exp_b[k] <= next_out(exp_b[k], rst, enb, web, ssrb, fit({dipb, dib}),
                           mdl_mem[addrb], INIT_B_V, SRVAL_B_V, b_mode(k));
    end
    if (ena && wea) mdl_mem[addra] <= fit({dipa, dia});
    if (enb && web) mdl_mem[addrb] <= fit({dipb, dib});
    if (rst) chk_en <= 1'b1;
  end

  // Every-cycle comparison, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("model_dut%0d_a", k), act_a[k], exp_a[k]);
        check($sformatf("model_dut%0d_b", k), act_b[k], exp_b[k]);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0; ssra = 1'b0; dia = 16'h0; dipa = 2'b00;
    enb = 1'b0; web = 1'b0; ssrb = 1'b0; dib = 16'h0; dipb = 2'b00;
  endtask

  int nz;

  initial begin
    addra = '0; addrb = '0;
    idle();

    // Reset loads INIT and does not block a simultaneous write.
    rst = 1'b1; enb = 1'b1; web = 1'b1; addrb = 10'd5; dib = 16'hBEEF; dipb = 2'b10;
    cyc();
    check("rst_doa",  18'(if0.DOA),  18'h1234);
    check("rst_dopa", 18'(if0.DOPA), PAR ? 18'h3 : 18'h0);
    check("rst_dob",  18'(if0.DOB),  18'h0000);
    rst = 1'b0;
    idle(); ena = 1'b1; addra = 10'd5;
    cyc();
    check("preload_doa",  18'(if0.DOA),  18'hBEEF);
    check("preload_dopa", 18'(if0.DOPA), PAR ? 18'h2 : 18'h0);

    // Port B fills 0..7, port A reads 0..9 back with one-cycle latency.
    idle();
    for (int i = 0; i < 8; i++) begin
      enb = 1'b1; web = 1'b1; addrb = 10'(i); dib = 16'hF81F; dipb = 2'b01;
      cyc();
    end
    idle();
    for (int i = 0; i < 10; i++) begin
      ena = 1'b1; addra = 10'(i);
      cyc();
      check($sformatf("fill_rd%0d", i), 18'(if0.DOA), (i < 8) ? 18'hF81F : 18'h0);
      check($sformatf("fill_par%0d", i), 18'(if0.DOPA), (i < 8 && PAR) ? 18'h1 : 18'h0);
    end

    // Scanline copy: read-and-clear sweep, then a sweep over the cleared line.
    idle(); enb = 1'b1; web = 1'b1; addrb = 10'd100; dib = 16'h07E0;
    cyc();
    idle();
    for (int i = 0; i < 640; i++) begin
      ena = 1'b1; wea = 1'b1; dia = 16'h0; addra = 10'(i);
      cyc();
      if (i == 100) check("scan_pix100", 18'(if0.DOA), 18'h07E0);
      if (i == 7)   check("scan_pix7",   18'(if0.DOA), 18'hF81F);
    end
    nz = 0;
    for (int i = 0; i < 640; i++) begin
      ena = 1'b1; wea = 1'b1; dia = 16'h0; addra = 10'(i);
      cyc();
      if (if0.DOA !== 16'h0) nz++;
    end
    check("scan2_nonzero_count", 18'(nz), 18'h0);

    // Same-address collisions.
    idle();
    ena = 1'b1; wea = 1'b1; addra = 10'd12; dia = 16'hAAAA;
    enb = 1'b1; web = 1'b1; addrb = 10'd12; dib = 16'h5555;
    cyc();
    idle(); ena = 1'b1; addra = 10'd12;
    cyc();
    check("coll_ww_b_wins", 18'(if0.DOA), 18'h5555);
    idle(); enb = 1'b1; web = 1'b1; addrb = 10'd20; dib = 16'h2222;
    cyc();
    idle();
    ena = 1'b1; wea = 1'b1; addra = 10'd20; dia = 16'h1111;
    enb = 1'b1; addrb = 10'd20;
    cyc();
    check("coll_rd_old", 18'(if0.DOB), 18'h2222);
    idle(); enb = 1'b1; addrb = 10'd20;
    cyc();
    check("coll_rd_new", 18'(if0.DOB), 18'h1111);

    // Port B write modes: 16'h00FF over 16'hFF00, prior DOB = 16'h5555.
    idle(); enb = 1'b1; web = 1'b1; addrb = 10'd30; dib = 16'hFF00;
    cyc();
    idle(); enb = 1'b1; addrb = 10'd12;
    cyc();
    idle(); enb = 1'b1; web = 1'b1; addrb = 10'd30; dib = 16'h00FF;
    cyc();
    check("wm_write_first", 18'(if0.DOB), 18'h00FF);
    check("wm_read_first",  18'(if1.DOB), 18'hFF00);
    check("wm_no_change",   18'(if2.DOB), 18'h5555);
    idle(); enb = 1'b1; addrb = 10'd30;
    cyc();
    check("wm_nc_stored", 18'(if2.DOB), 18'h00FF);

    // SSR with a concurrent write; SSR and WE ignored while disabled.
    idle(); enb = 1'b1; web = 1'b1; ssrb = 1'b1; addrb = 10'd3; dib = 16'h1357;
    cyc();
    check("ssr_dob", 18'(if0.DOB), 18'hABCD);
    check("ssr_dob_nc", 18'(if2.DOB), 18'hABCD);
    idle(); enb = 1'b1; addrb = 10'd3;
    cyc();
    check("ssr_write_landed", 18'(if0.DOB), 18'h1357);
    idle(); ssrb = 1'b1; web = 1'b1; addrb = 10'd3; dib = 16'hFFFF;
    cyc();
    check("en0_hold", 18'(if0.DOB), 18'h1357);
    idle(); enb = 1'b1; addrb = 10'd3;
    cyc();
    check("en0_no_write", 18'(if1.DOB), 18'h1357);

    // Reset mid-run overrides an enabled read.
    idle(); rst = 1'b1; ena = 1'b1; addra = 10'd12;
    cyc();
    check("rst_again_doa", 18'(if0.DOA), 18'h1234);
    rst = 1'b0;
    idle();
    cyc();
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
